// File: rtl/coproc_pkg.sv
// Shared coprocessor definitions: operand widths and the loader state set.
// The ALU stages import this package so their operand widths match the loader's.
package coproc_pkg;

    localparam int ELEM_W = 8;                // width of one matrix element and of the scalar
    localparam int DIM    = 5;                // square matrix dimension
    localparam int N_ELEM = DIM * DIM;        // elements per matrix
    localparam int MAT_W  = N_ELEM * ELEM_W;  // packed matrix width
    localparam int CNT_W  = $clog2(N_ELEM);   // element index width

    typedef enum logic [2:0] {
        IDLE,
        LOAD_A,
        LOAD_B,
        LOAD_ESC,
        DONE
    } carga_estado_t;

    // True when the index addresses the last element of a matrix.
    function automatic logic is_last_elem(input logic [CNT_W-1:0] idx);
        return idx == CNT_W'(N_ELEM - 1);
    endfunction

endpackage

// File: rtl/empacota_matriz.sv
// Counter-indexed byte writer: stores one element into a packed row-major matrix
// register. Element k occupies bits [k*ELEM_W +: ELEM_W].
module empacota_matriz
    import coproc_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [CNT_W-1:0]  idx,
    input  logic [ELEM_W-1:0] data,
    output logic [MAT_W-1:0]  mat
);

    // Write the addressed element on an enabled beat; untouched elements hold.
    always_ff @(posedge clk) begin
        // NOTE: the operand register is cleared on reset because it drives an output
        // that must read 0 after reset; it is a small flop bank, not a RAM.
        if (rst) begin
            mat <= '0;
        end else begin
            for (int k = 0; k < N_ELEM; k++) begin
                if (we && idx == CNT_W'(k)) begin
                    mat[k*ELEM_W +: ELEM_W] <= data;
                end
            end
        end
    end

endmodule

// File: rtl/carrega_matrizes.sv
// Operand loader for the matrix ALU. Assembles a byte stream into matrix A, then
// either matrix B or the scalar, and flags when the operands are complete.
// Optional feature: define CARREGA_ABORT_EN to add the 'abort' input, which
// cancels an in-progress load and returns to IDLE.
module carrega_matrizes
    import coproc_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              op_escalar,
`ifdef CARREGA_ABORT_EN
    input  logic              abort,
`endif
    input  logic              in_valid,
    input  logic [ELEM_W-1:0] in_data,
    output logic              in_ready,
    output logic [MAT_W-1:0]  matriz_a,
    output logic [MAT_W-1:0]  matriz_b,
    output logic [ELEM_W-1:0] data_escalar,
    output logic              matrizes_prontas,
    output logic              done
);

    carga_estado_t    state;
    carga_estado_t    state_next;
    logic             op_q;         // 1 = second operand is the scalar
    logic [CNT_W-1:0] cnt;          // element index within the current matrix
    logic             abort_req;
    logic             beat;         // a byte is transferred this cycle
    logic             last_elem;
    logic             accept_start;
    logic             we_a;
    logic             we_b;
    logic             we_esc;

`ifdef CARREGA_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    // An abort discards a beat presented in the same cycle.
    assign beat      = in_valid && in_ready && !abort_req;
    assign last_elem = is_last_elem(cnt);

    // Next-state decode and per-register write enables.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // one unassigned, which would infer a latch.
        state_next   = state;
        accept_start = 1'b0;
        we_a         = 1'b0;
        we_b         = 1'b0;
        we_esc       = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    accept_start = 1'b1;
                    state_next   = LOAD_A;
                end
            end
            LOAD_A: begin
                we_a = beat;
                if (abort_req) begin
                    state_next = IDLE;
                end else if (beat && last_elem) begin
                    state_next = op_q ? LOAD_ESC : LOAD_B;
                end
            end
            LOAD_B: begin
                we_b = beat;
                if (abort_req) begin
                    state_next = IDLE;
                end else if (beat && last_elem) begin
                    state_next = DONE;
                end
            end
            LOAD_ESC: begin
                we_esc = beat;
                if (abort_req) begin
                    state_next = IDLE;
                end else if (beat) begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register plus registered decodes of the next state.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            state            <= IDLE;
            in_ready         <= 1'b0;
            done             <= 1'b0;
            matrizes_prontas <= 1'b0;
        end else begin
            state            <= state_next;
            in_ready         <= (state_next == LOAD_A) || (state_next == LOAD_B) ||
                                (state_next == LOAD_ESC);
            done             <= (state_next == DONE) && (state != DONE);
            matrizes_prontas <= (state_next == DONE);
        end
    end

    // Operation latch, sampled only when a start is honoured.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q <= 1'b0;
        end else if (accept_start) begin
            op_q <= op_escalar;
        end
    end

    // Element counter: restarts on start and after the last element, never wraps past it.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (accept_start) begin
            cnt <= '0;
        end else if (we_a || we_b) begin
            cnt <= last_elem ? '0 : cnt + 1'b1;
        end
    end

    // Scalar operand register, written only on its own beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_escalar <= '0;
        end else if (we_esc) begin
            data_escalar <= in_data;
        end
    end

    empacota_matriz u_matriz_a (
        .clk  (clk),
        .rst  (rst),
        .we   (we_a),
        .idx  (cnt),
        .data (in_data),
        .mat  (matriz_a)
    );

    empacota_matriz u_matriz_b (
        .clk  (clk),
        .rst  (rst),
        .we   (we_b),
        .idx  (cnt),
        .data (in_data),
        .mat  (matriz_b)
    );

endmodule
